adder_serial_ctrl: RTL and testbench
====================================

Name: adder_serial_ctrl

Overview:
Nibble-serial wide adder controller. It sequences one 4-bit adder slice (with carry-in) over NIBBLES cycles to add two 4*NIBBLES-bit operands. Carry is held in a register between nibbles. Operands enter through a valid/ready input handshake and the result leaves through a valid/ready output handshake. It sits above the 4-bit adder cell and lets one adder of any logic family serve wide additions.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  sum bits
out_cout  output  1  carry out of the top nibble

Behaviour:
- Single clock clk; reset is synchronous and active-low on rst_n. It is sampled only at the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, nibble counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: latch in_a/in_b into operand registers, clear the counter and carry, clear out_sum, and go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle the slice adds a_reg[4k+3:4k] + b_reg[4k+3:4k] + carry, where k = counter.
  - At the edge: sum nibble is written to out_sum[4k+3:4k], carry <= slice cout, counter++.
  - When k = NIBBLES-1, the final cout is also written to out_cout and the FSM goes to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable.
  - When out_ready=1 at an edge: out_valid drops to 0 and the FSM returns to IDLE. in_ready is 1 from the next cycle.
- Latency and throughput:
  - Operands accepted at edge T; out_valid rises after edge T+NIBBLES.
  - Minimum issue interval is NIBBLES+2 cycles when out_ready is tied high.
- Arithmetic: unsigned modulo 2^W. The carry register is exactly 1 bit and no intermediate value is wider than 5 bits. {out_cout,out_sum} equals in_a+in_b.
- Boundary conditions:
  - Carry ripples across every slice boundary, e.g. all-ones + 1.
  - Counter wrap is never observed; the counter is cleared on acceptance.
  - out_ready asserted outside DONE has no effect.
  - in_valid and out_ready both high in DONE: only the result handshake happens. The new operands are taken in IDLE on the following cycle.
  - rst_n low in any state, including mid-RUN, aborts the operation and restores all reset values on that edge. The partial result is discarded.
- The slice is purely combinational; all state lives in this block.

Optional Feature:
Macro ADDER_SERIAL_SUB_EN.
- Defined:
  - Extra input port in_sub (1 bit) is latched with the operands.
  - If in_sub=1, each B nibble is inverted into the slice and the carry is initialised to 1, so out_sum = in_a - in_b mod 2^W.
  - out_cout = 1 means no borrow (in_a >= in_b).
- Undefined: port in_sub is absent and the block is add-only. Behaviour is bit-identical to the in_sub=0 case.

Decomposition:
- Shared package adder_serial_pkg:
  - state typedef (IDLE/RUN/DONE)
  - NIBBLE_W=4 constant
  - counter-width function clog2(NIBBLES)
- Sub-module adder_4bit_cin: combinational 4-bit adder with carry-in. Inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout. Instantiated once.

Test Plan:
1. NIBBLES=4, in_a=0x1234, in_b=0x4321, out_ready=1 -> out_sum=0x5555, out_cout=0, out_valid 4 cycles after acceptance, in_ready low during RUN/DONE.
2. in_a=0xFFFF, in_b=0x0001 -> out_sum=0x0000, out_cout=1; also 0x0FFF+0x0001 -> 0x1000, out_cout=0 (full carry ripple).
3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_sum held constant and in_valid pulses ignored; out_ready=1 -> return to IDLE, next operand pair 0x8000+0x8000 -> 0x0000, out_cout=1.
4. Reset mid-RUN: rst_n=0 at counter=2 -> next cycle in_ready=1, out_valid=0, out_sum=0, out_cout=0; a fresh 0x00FF+0x0001 then gives 0x0100.
5. Exhaustive low nibble sweep: NIBBLES=2, a,b in 0..255 (upper bits included) -> {out_cout,out_sum}=a+b for all 65536 pairs.
6. With ADDER_SERIAL_SUB_EN: 0x0005-0x0007 -> out_sum=0xFFFE, out_cout=0; 0x0007-0x0005 -> 0x0002, out_cout=1.

Source files
------------

// File: rtl/adder_serial_pkg.sv
// Shared definitions for the nibble-serial adder controller.
package adder_serial_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Counter width for a nibble index; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned nibbles);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < nibbles) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/adder_4bit_cin.sv
// Combinational 4-bit adder slice with carry-in.
module adder_4bit_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_full;

    // 5-bit result: low nibble is the sum, top bit the carry out.
    always_comb begin
        w_full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    end

    assign sum  = w_full[3:0];
    assign cout = w_full[4];

endmodule

// File: rtl/adder_serial_ctrl.sv
// Nibble-serial wide adder controller: one 4-bit slice is walked over NIBBLES
// cycles, with the carry held in a 1-bit register between nibbles.
// Optional subtract mode is enabled by defining ADDER_SERIAL_SUB_EN.
module adder_serial_ctrl
    import adder_serial_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
`ifdef ADDER_SERIAL_SUB_EN
    input  logic                          in_sub,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_sum,
    output logic                          out_cout
);

    localparam int unsigned W    = NIBBLE_W * NIBBLES;
    localparam int unsigned CntW = clog2(NIBBLES);

    state_e              r_state;
    state_e              w_state_next;

    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic                r_cout;
    logic                r_carry;
    logic [CntW-1:0]     r_cnt;

    logic                w_accept;
    logic                w_last;
    int unsigned         w_base;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_raw;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_cout;
    logic                w_carry_init;

    assign w_accept = (r_state == StIdle) && in_valid;
    assign w_last   = (r_cnt == CntW'(NIBBLES - 1));
    assign w_base   = NIBBLE_W * 32'(r_cnt);
    assign w_a_nib  = r_a[w_base +: NIBBLE_W];
    assign w_b_raw  = r_b[w_base +: NIBBLE_W];

`ifdef ADDER_SERIAL_SUB_EN
    logic r_sub;

    // Subtract is A + ~B + 1: invert B per nibble and seed the carry with 1.
    always_comb begin
        w_b_nib      = w_b_raw ^ {NIBBLE_W{r_sub}};
        w_carry_init = in_sub;
    end

    // Operation mode is captured together with the operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= in_sub;
        end
    end
`else
    // Add-only build: B passes straight through and the carry starts at 0.
    always_comb begin
        w_b_nib      = w_b_raw;
        w_carry_init = 1'b0;
    end
`endif

    adder_4bit_cin u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_sum_nib),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (in_valid)  w_state_next = StRun;
            StRun:  if (w_last)    w_state_next = StDone;
            StDone: if (out_ready) w_state_next = StIdle;
            default:               w_state_next = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            StIdle:  in_ready  = 1'b1;
            StRun:   ;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture operands on accept, then one nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_sum   <= '0;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
        end else if (r_state == StRun) begin
            r_sum[w_base +: NIBBLE_W] <= w_sum_nib;
            r_carry                   <= w_cout;
            r_cnt                     <= r_cnt + CntW'(1);
            if (w_last) begin
                r_cout <= w_cout;
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Self-checking bench for adder_serial_ctrl (NIBBLES=4, 16-bit operands).
module tb_adder_serial_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int checks;
    int errors;

    adder_serial_ctrl #(
        .NIBBLES (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef ADDER_SERIAL_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for result, optional stall, handshake.
    // With pulse set, in_valid toggles during the stall and a 0x8000+0x8000
    // pair is already presented when the result handshake happens.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input int stall, input bit pulse);
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        int           n;
        if (sub) begin
            exp_sum  = a - b;
            exp_cout = (a >= b);
        end else begin
            {exp_cout, exp_sum} = {1'b0, a} + {1'b0, b};
        end

        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_idle", in_ready, 1);

        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_sub = ~sub;

        n = 0;
        while (out_valid !== 1'b1 && n < 4 * N) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk); #1; n++;
        end
        chk("latency", n, N);
        chk("sum", out_sum, exp_sum);
        chk("cout", out_cout, exp_cout);

        for (int i = 0; i < stall; i++) begin
            if (pulse) begin
                in_valid = i[0];
                in_a = W'($urandom); in_b = W'($urandom);
            end
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, exp_sum);
            chk("hold_cout", out_cout, exp_cout);
            chk("hold_in_ready", in_ready, 0);
        end

        if (pulse) begin
            in_valid = 1'b1; in_a = 16'h8000; in_b = 16'h8000; in_sub = 1'b0;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add and full carry ripple cases.
        run_txn(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_txn(16'h0FFF, 16'h0001, 1'b0, 0, 1'b0);

        // Backpressure with ignored in_valid pulses, then the queued pair.
        run_txn(16'h1111, 16'h2222, 1'b0, 5, 1'b1);
        run_txn(16'h8000, 16'h8000, 1'b0, 0, 1'b0);

        // Abort mid-RUN once two nibbles have been written.
        in_a = 16'hFFFF; in_b = 16'h0000; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_sum", out_sum, 0);
        chk("abort_out_cout", out_cout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

        // Small operands including the low byte boundaries.
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_txn(ra, rb, 1'b0, 0, 1'b0);
        end
        run_txn(16'h00FF, 16'h00FF, 1'b0, 0, 1'b0);

        // Full-width random with random output stalls.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef ADDER_SERIAL_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_txn(ra, rb, rs, $urandom_range(0, 3), 1'b0);
        end

`ifdef ADDER_SERIAL_SUB_EN
        run_txn(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        run_txn(16'h0007, 16'h0005, 1'b1, 0, 1'b0);
        run_txn(16'h1234, 16'h1234, 1'b1, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
